muldiv_sequencer: RTL
=====================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand/HI/LO width; counter width is clog2(WIDTH)+1.
REQ-002 Port: clk  in  1  single clock; all state changes on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: i_start  in  1  request a MULT/MULTU/DIV/DIVU operation from decode.
REQ-005 Port: i_op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 Port: i_rs, i_rt  in  WIDTH each  operands; Rs is the dividend, Rt is the divisor.
REQ-007 Port: i_mthi, i_mtlo  in  1 each  direct write of i_wdata into HI or LO.
REQ-008 Port: i_wdata  in  WIDTH  MTHI/MTLO data.
REQ-009 Port: i_hilo_rd  in  1  decode holds MFHI/MFLO.
REQ-010 Port: i_flush  in  1  abort the in-flight operation.
REQ-011 Port: o_hi, o_lo  out  WIDTH each  architectural HI/LO registers.
REQ-012 Port: o_busy  out  1  high whenever state is not IDLE.
REQ-013 Port: o_stall  out  1  combinational pipeline stall request.
REQ-014 Port: o_done  out  1  one-cycle completion pulse.
REQ-015 Port: o_div_zero  out  1  one-cycle pulse when a divide has a zero divisor.

Function
REQ-016 FSM states: IDLE, RUN, FIX; IDLE->RUN on accepted start, RUN->FIX when the counter reaches 0, FIX->IDLE always.
REQ-017 Start is accepted only in IDLE; i_start while busy is ignored and o_stall holds decode.
REQ-018 On acceptance: signed ops latch |i_rs|, |i_rt| and the result signs; unsigned ops latch the raw operands; counter loads WIDTH-1.
REQ-019 RUN: one iteration per cycle for WIDTH cycles (shift-add multiply, restoring divide), so an accepted start at edge N reaches FIX at edge N+WIDTH.
REQ-020 FIX: apply sign correction and write HI/LO at edge N+WIDTH+1, with o_done high for the following cycle only.
REQ-021 Multiply result: HI = product[2W-1:W], LO = product[W-1:0], where product is the full 2W-bit value.
REQ-022 Divide result: LO = quotient, HI = remainder; quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs).
REQ-023 DIV with rs=0x80000000 and rt=0xFFFFFFFF wraps: LO=0x80000000, HI=0.
REQ-024 Divide with rt=0: no RUN; o_div_zero pulses one cycle after acceptance; HI/LO are unchanged; state stays IDLE.
REQ-025 i_mthi/i_mtlo in IDLE write on the next edge; while busy they are ignored and o_stall is asserted.
REQ-026 i_start and i_mthi/i_mtlo together in IDLE: the start wins and the moves are dropped.
REQ-027 o_stall = o_busy AND (i_start OR i_hilo_rd OR i_mthi OR i_mtlo).
REQ-028 i_flush in any state: go to IDLE on the next edge, HI/LO unchanged, no o_done; i_flush also wins over a simultaneous i_start.

Reset
REQ-029 rst_n low: state=IDLE, counter=0, o_hi=0, o_lo=0, o_done=0, o_div_zero=0, o_busy=0, all datapath registers cleared, asynchronously.
REQ-030 Reset mid-RUN discards the operation; the first edge after deassertion samples inputs normally.

Configuration
REQ-031 Macro MULDIV_DIVIDE_EN defined: DIV/DIVU are supported as specified above.
REQ-032 Macro MULDIV_DIVIDE_EN undefined: the divider logic is omitted; DIV/DIVU starts are ignored (no busy, no done, HI/LO unchanged); o_div_zero is tied 0.

Verification
REQ-033 MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> after 33 edges HI=0xFFFFFFFE, LO=0x00000001, o_done high 1 cycle.
REQ-034 MULT rs=-3, rt=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; i_hilo_rd during RUN -> o_stall=1 every busy cycle.
REQ-035 DIV rs=-7, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU rs=100, rt=7 -> LO=14, HI=2.
REQ-036 DIV rt=0 with HI=0x1234 -> o_div_zero pulse, o_busy stays 0, HI=0x1234.
REQ-037 Start MULTU, i_flush at RUN cycle 10 -> IDLE next cycle, HI/LO unchanged, no o_done; then MTLO 0xA5 -> LO=0xA5.
REQ-038 rst_n asserted mid-RUN -> all outputs 0 immediately; DIV 0x80000000/-1 after reset -> LO=0x80000000, HI=0.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
//   A start in IDLE latches operand magnitudes, runs WIDTH shift-add (multiply)
//   or restoring-divide iterations, then applies sign correction in FIX and
//   writes HI/LO. MTHI/MTLO write HI/LO directly while idle.
// Build option: define MULDIV_DIVIDE_EN to include the divider; without it
//   DIV/DIVU starts are ignored and o_div_zero is tied low.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   i_start, i_op       operation request (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   i_rs, i_rt          operands (rs = dividend, rt = divisor)
//   i_mthi, i_mtlo      direct HI/LO write of i_wdata
//   i_hilo_rd           decode is reading HI/LO (MFHI/MFLO)
//   i_flush             abort in-flight operation
//   o_hi, o_lo          architectural HI/LO
//   o_busy, o_stall     not-idle flag, combinational decode stall
//   o_done, o_div_zero  one-cycle completion / divide-by-zero pulses
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_hilo_rd,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo,
    output logic             o_busy,
    output logic             o_stall,
    output logic             o_done,
    output logic             o_div_zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc;    // product high half, or partial remainder
    logic [WIDTH-1:0]   lo_q;   // multiplier -> product low half, or dividend -> quotient
    logic [WIDTH-1:0]   opa;    // multiplicand or divisor magnitude
    logic               neg_q;  // negate product / quotient in FIX

    logic               sgn_op, is_div, start_ok, go_run;
    logic [WIDTH-1:0]   rs_abs, rt_abs, mul_add;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod_mag, prod_fix;

    assign sgn_op   = ~i_op[0];
    assign is_div   = i_op[1];
    assign rs_abs   = (sgn_op && i_rs[WIDTH-1]) ? -i_rs : i_rs;
    assign rt_abs   = (sgn_op && i_rt[WIDTH-1]) ? -i_rt : i_rt;

    // Shift-add step: add multiplicand into the high half when the current
    // multiplier bit is set, then shift {carry, acc, lo_q} right by one.
    assign mul_add  = lo_q[0] ? opa : '0;
    assign mul_sum  = {1'b0, acc} + {1'b0, mul_add};
    assign prod_mag = {acc, lo_q};
    assign prod_fix = neg_q ? -prod_mag : prod_mag;

    assign o_busy   = (state != IDLE);
    assign o_stall  = o_busy & (i_start | i_hilo_rd | i_mthi | i_mtlo);

`ifdef MULDIV_DIVIDE_EN
    logic               op_div, neg_r, div_zero;
    logic [WIDTH:0]     div_sh, div_diff;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign start_ok = i_start & ~i_flush & (state == IDLE);
    assign div_zero = start_ok & is_div & (i_rt == '0);
    assign go_run   = start_ok & ~div_zero;
    // Restoring step: partial remainder < divisor, so it always fits WIDTH bits.
    assign div_sh   = {acc, lo_q[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opa};
    assign quo_fix  = neg_q ? -lo_q : lo_q;
    assign rem_fix  = neg_r ? -acc : acc;
`else
    assign start_ok   = i_start & ~i_flush & ~is_div & (state == IDLE);
    assign go_run     = start_ok;
    assign o_div_zero = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (i_flush) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (go_run) state_nxt = RUN;
                RUN:     if (cnt == '0) state_nxt = FIX;
                FIX:     state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            acc    <= '0;
            lo_q   <= '0;
            opa    <= '0;
            neg_q  <= 1'b0;
            o_hi   <= '0;
            o_lo   <= '0;
            o_done <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            op_div     <= 1'b0;
            neg_r      <= 1'b0;
            o_div_zero <= 1'b0;
`endif
        end else begin
            o_done <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
            o_div_zero <= div_zero;
`endif
            if (i_flush) begin
                cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (go_run) begin
                            acc   <= '0;
                            cnt   <= CW'(WIDTH - 1);
                            neg_q <= sgn_op & (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
`ifdef MULDIV_DIVIDE_EN
                            op_div <= is_div;
                            neg_r  <= sgn_op & i_rs[WIDTH-1];
                            opa    <= is_div ? rt_abs : rs_abs;
                            lo_q   <= is_div ? rs_abs : rt_abs;
`else
                            opa    <= rs_abs;
                            lo_q   <= rt_abs;
`endif
                        end else if (!start_ok) begin
                            // An accepted start (incl. divide-by-zero) drops the moves.
                            if (i_mthi) o_hi <= i_wdata;
                            if (i_mtlo) o_lo <= i_wdata;
                        end
                    end
                    RUN: begin
                        if (cnt != '0) cnt <= cnt - CW'(1);
`ifdef MULDIV_DIVIDE_EN
                        if (op_div) begin
                            if (!div_diff[WIDTH]) begin
                                acc  <= div_diff[WIDTH-1:0];
                                lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                            end else begin
                                acc  <= div_sh[WIDTH-1:0];
                                lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                            end
                        end else
`endif
                        begin
                            acc  <= mul_sum[WIDTH:1];
                            lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
                        end
                    end
                    FIX: begin
                        o_done <= 1'b1;
`ifdef MULDIV_DIVIDE_EN
                        if (op_div) begin
                            o_hi <= rem_fix;
                            o_lo <= quo_fix;
                        end else
`endif
                        begin
                            o_hi <= prod_fix[2*WIDTH-1:WIDTH];
                            o_lo <= prod_fix[WIDTH-1:0];
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
